// File: rtl/mem_lsu.sv
// Load/store unit driving a word-wide, combinational-read data memory port.
// Define LSU_RMW_EN to enable sub-word stores via read-modify-write; otherwise they are rejected.
module mem_lsu #(
  parameter int unsigned MEM_BYTES = 16384,
  parameter logic [31:0] ERR_RDATA = 32'h00000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_we
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, state_n;
  logic        lat_we, lat_unsigned;
  logic [1:0]  lat_size, lat_lane;
  logic [31:0] lat_wdata;

  logic        rsp_valid_n, rsp_err_n, mem_we_n;
  logic [31:0] rsp_rdata_n, mem_address_n, mem_data_in_n;

  logic        accept_c, req_err_c, sub_store_err_c;
  logic [4:0]  shamt_c;
  logic [31:0] lane_c, lane_mask_c, load_data_c, merged_c;

  assign req_ready = (state == IDLE);
  assign accept_c  = req_valid && (state == IDLE);

  // Request legality, evaluated on the live request fields at accept
  always_comb begin
`ifdef LSU_RMW_EN
    sub_store_err_c = 1'b0;
`else
    sub_store_err_c = req_we && (req_size != 2'b10);
`endif
    req_err_c = (req_size == 2'b11)
             || ((req_size == 2'b01) && req_addr[0])
             || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
             || (req_addr >= 32'(MEM_BYTES))
             || sub_store_err_c;
  end

  // Little-endian lane extraction and merge against the word read back from memory
  always_comb begin
    shamt_c     = {lat_lane, 3'b000};
    lane_c      = mem_data_out >> shamt_c;
    lane_mask_c = (lat_size == 2'b00) ? (32'h000000FF << shamt_c) : (32'h0000FFFF << shamt_c);
    merged_c    = (mem_data_out & ~lane_mask_c) | ((lat_wdata << shamt_c) & lane_mask_c);
    case (lat_size)
      2'b00:   load_data_c = lat_unsigned ? {24'h000000, lane_c[7:0]}
                                          : {{24{lane_c[7]}}, lane_c[7:0]};
      2'b01:   load_data_c = lat_unsigned ? {16'h0000, lane_c[15:0]}
                                          : {{16{lane_c[15]}}, lane_c[15:0]};
      default: load_data_c = mem_data_out;
    endcase
  end

  // Next state and next values of every registered output
  always_comb begin
    state_n       = state;
    rsp_valid_n   = 1'b0;
    rsp_err_n     = 1'b0;
    rsp_rdata_n   = 32'h00000000;
    mem_we_n      = 1'b0;
    mem_address_n = mem_address;
    mem_data_in_n = mem_data_in;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err_c) begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = 1'b1;
            rsp_rdata_n = ERR_RDATA;
          end else if (req_we && (req_size == 2'b10)) begin
            state_n       = WRITE;
            mem_address_n = {req_addr[31:2], 2'b00};
            mem_data_in_n = req_wdata;
            mem_we_n      = 1'b1;
          end else begin
            state_n       = READ;
            mem_address_n = {req_addr[31:2], 2'b00};
          end
        end
      end
      READ: begin
        if (lat_we) begin
          state_n       = WRITE;
          mem_data_in_n = merged_c;
          mem_we_n      = 1'b1;
        end else begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          rsp_rdata_n = load_data_c;
        end
      end
      WRITE: begin
        state_n     = RESP;
        rsp_valid_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= 32'h00000000;
      mem_address  <= 32'h00000000;
      mem_data_in  <= 32'h00000000;
      mem_we       <= 1'b0;
      lat_we       <= 1'b0;
      lat_unsigned <= 1'b0;
      lat_size     <= 2'b00;
      lat_lane     <= 2'b00;
      lat_wdata    <= 32'h00000000;
    end else begin
      rsp_valid   <= rsp_valid_n;
      rsp_err     <= rsp_err_n;
      rsp_rdata   <= rsp_rdata_n;
      mem_address <= mem_address_n;
      mem_data_in <= mem_data_in_n;
      mem_we      <= mem_we_n;
      if (accept_c) begin
        lat_we       <= req_we;
        lat_unsigned <= req_unsigned;
        lat_size     <= req_size;
        lat_lane     <= req_addr[1:0];
        lat_wdata    <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu against a small word-array memory model.
module tb_mem_lsu;

`ifdef LSU_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif
  localparam logic [31:0] ERR_RDATA = 32'h00000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_address, mem_data_in, mem_data_out;

  logic [31:0] mem [0:4095];
  int checks = 0;
  int errors = 0;

  mem_lsu #(.MEM_BYTES(16384), .ERR_RDATA(ERR_RDATA)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  assign mem_data_out = mem[mem_address[13:2]];
  always @(posedge clk) if (mem_we) mem[mem_address[13:2]] <= mem_data_in;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nwe;
    logic [31:0] waddr;
    logic [31:0] wword;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata, input int lat,
                              input int nwe, input logic [31:0] waddr, input logic [31:0] wword);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.lat = lat; v.nwe = nwe; v.waddr = waddr; v.wword = wword;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // One request from idle: latency, response fields, write-port activity, response clear
  task automatic run_req(input vec_t v, input string tag);
    int lat, nwe;
    logic err;
    logic [31:0] rd, wa, wd;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; nwe = 0; err = 1'b0; rd = 32'h0; wa = 32'h0; wd = 32'h0;
    for (int n = 1; n <= 10; n++) begin
      if (mem_we) begin nwe++; wa = mem_address; wd = mem_data_in; end
      if (rsp_valid) begin lat = n; err = rsp_err; rd = rsp_rdata; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
    chk({tag, "_err"}, 32'(err), 32'(v.err));
    chk({tag, "_rdata"}, rd, v.rdata);
    chk({tag, "_nwe"}, 32'(nwe), 32'(v.nwe));
    if (v.nwe > 0) begin
      chk({tag, "_waddr"}, wa, v.waddr);
      chk({tag, "_wdata"}, wd, v.wword);
    end
    @(posedge clk); #1;
    chk({tag, "_clr"}, 32'({rsp_valid, rsp_err}) | rsp_rdata, 32'd0);
  endtask

  vec_t vecs[16];
  vec_t b2b[3];
  logic [31:0] b2b_exp[3];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    //             we    sz     u     addr          wdata         err   rdata                                     lat       nwe     waddr   wword
    vecs[0]  = mk(1'b1, 2'b10, 1'b0, 32'h10,   32'h800000FF, 1'b0, 32'h0,                                     2,        1,      32'h10, 32'h800000FF);
    vecs[1]  = mk(1'b0, 2'b00, 1'b0, 32'h10,   32'h0,        1'b0, 32'hFFFFFFFF,                              2,        0,      32'h0,  32'h0);
    vecs[2]  = mk(1'b0, 2'b00, 1'b1, 32'h10,   32'h0,        1'b0, 32'h000000FF,                              2,        0,      32'h0,  32'h0);
    vecs[3]  = mk(1'b0, 2'b01, 1'b0, 32'h12,   32'h0,        1'b0, 32'hFFFF8000,                              2,        0,      32'h0,  32'h0);
    vecs[4]  = mk(1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        1'b0, 32'h00008000,                              2,        0,      32'h0,  32'h0);
    vecs[5]  = mk(1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        1'b0, 32'h800000FF,                              2,        0,      32'h0,  32'h0);
    vecs[6]  = mk(1'b1, 2'b00, 1'b0, 32'h11,   32'hFFFFFFAB, !RMW, RMW ? 32'h0 : ERR_RDATA,                    RMW ? 3 : 1, RMW ? 1 : 0, 32'h10, 32'h8000ABFF);
    vecs[7]  = mk(1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        1'b0, RMW ? 32'h8000ABFF : 32'h800000FF,          2,        0,      32'h0,  32'h0);
    vecs[8]  = mk(1'b1, 2'b01, 1'b0, 32'h12,   32'hFFFF1234, !RMW, RMW ? 32'h0 : ERR_RDATA,                    RMW ? 3 : 1, RMW ? 1 : 0, 32'h10, 32'h1234ABFF);
    vecs[9]  = mk(1'b0, 2'b10, 1'b0, 32'h13,   32'h0,        1'b1, ERR_RDATA,                                 1,        0,      32'h0,  32'h0);
    vecs[10] = mk(1'b0, 2'b01, 1'b0, 32'h11,   32'h0,        1'b1, ERR_RDATA,                                 1,        0,      32'h0,  32'h0);
    vecs[11] = mk(1'b0, 2'b11, 1'b0, 32'h10,   32'h0,        1'b1, ERR_RDATA,                                 1,        0,      32'h0,  32'h0);
    vecs[12] = mk(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0,        1'b1, ERR_RDATA,                                 1,        0,      32'h0,  32'h0);
    vecs[13] = mk(1'b0, 2'b00, 1'b0, 32'h3FFF, 32'h0,        1'b0, 32'h0,                                     2,        0,      32'h0,  32'h0);
    vecs[14] = mk(1'b0, 2'b01, 1'b0, 32'h10,   32'h0,        1'b0, RMW ? 32'hFFFFABFF : 32'h000000FF,          2,        0,      32'h0,  32'h0);
    vecs[15] = mk(1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        1'b0, RMW ? 32'h1234ABFF : 32'h800000FF,          2,        0,      32'h0,  32'h0);

    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp", 32'({rsp_valid, rsp_err, mem_we}), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_din", mem_data_in, 32'd0);
    @(negedge clk); resetn = 1'b1;

    for (int i = 0; i < 16; i++) run_req(vecs[i], $sformatf("v%0d", i));

    // Reset asserted in the middle of a word store's WRITE cycle
    begin
      int seen;
      @(negedge clk);
      req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h20; req_wdata = 32'h11223344; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstw_we_before", 32'(mem_we), 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("rstw_we_after", 32'(mem_we), 32'd0);
      chk("rstw_ready", 32'(req_ready), 32'd1);
      chk("rstw_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk); resetn = 1'b1;
      seen = 0;
      for (int n = 0; n < 3; n++) begin
        @(posedge clk); #1;
        if (rsp_valid) seen++;
      end
      chk("rstw_no_rsp", 32'(seen), 32'd0);
    end
    run_req(mk(1'b1, 2'b10, 1'b0, 32'h20, 32'h55667788, 1'b0, 32'h0, 2, 1, 32'h20, 32'h55667788), "post_rst_sw");
    run_req(mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h55667788, 2, 0, 32'h0, 32'h0), "post_rst_lw");

    // Three loads with req_valid held high throughout
    b2b[0] = mk(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 0, 0, 32'h0, 32'h0);
    b2b[1] = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 0, 0, 32'h0, 32'h0);
    b2b[2] = mk(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b0, 32'h0, 0, 0, 32'h0, 32'h0);
    b2b_exp[0] = 32'h55667788;
    b2b_exp[1] = RMW ? 32'h1234ABFF : 32'h800000FF;
    b2b_exp[2] = 32'h00000055;
    begin
      int acc, nrsp;
      bit will_acc;
      acc = 0; nrsp = 0;
      @(negedge clk);
      req_we = b2b[0].we; req_size = b2b[0].size; req_unsigned = b2b[0].uns;
      req_addr = b2b[0].addr; req_valid = 1'b1;
      for (int c = 0; c < 30 && nrsp < 3; c++) begin
        will_acc = req_valid && req_ready;
        @(posedge clk); #1;
        if (will_acc) begin
          acc++;
          if (acc < 3) begin
            req_we = b2b[acc].we; req_size = b2b[acc].size;
            req_unsigned = b2b[acc].uns; req_addr = b2b[acc].addr;
          end else begin
            req_valid = 1'b0;
          end
        end
        if (rsp_valid) begin
          if (nrsp < 3) chk($sformatf("b2b_rdata%0d", nrsp), rsp_rdata, b2b_exp[nrsp]);
          nrsp++;
        end
        @(negedge clk);
      end
      req_valid = 1'b0;
      for (int n = 0; n < 4; n++) begin
        @(posedge clk); #1;
        if (rsp_valid) nrsp++;
      end
      chk("b2b_accepts", 32'(acc), 32'd3);
      chk("b2b_rsps", 32'(nrsp), 32'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
